// File: rtl/ldtu_enc_pkg.sv
// Shared constants and state type for the LiTe-DTU sample encoder.
// Header codes identify the four 32-bit word formats sent to the serializer.
package ldtu_enc_pkg;

  localparam int NB_BASE = 6;
  localparam int N_BASE  = 5;
  localparam int NB_SIG  = 13;

  localparam logic [1:0] HDR_BASE_FULL  = 2'b01;
  localparam logic [3:0] HDR_BASE_PART  = 4'b1110;
  localparam logic [5:0] HDR_SIG_PAIR   = 6'b001010;
  localparam logic [5:0] HDR_SIG_SINGLE = 6'b001011;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    BASE_ACC = 2'd1,
    SIG_ACC  = 2'd2
  } state_t;

endpackage

// File: rtl/ldtu_enc_wordfmt.sv
// Combinational word formatter: builds the outgoing 32-bit word from the
// pending group and, for full groups, the sample that completes it.
module ldtu_enc_wordfmt
  import ldtu_enc_pkg::*;
(
  input  logic [1:0]                     i_state,
  input  logic [2:0]                     i_cnt,
  input  logic [(N_BASE-1)*NB_BASE-1:0]  i_base_acc,
  input  logic [NB_SIG-1:0]              i_sig_acc,
  input  logic [NB_SIG-1:0]              i_sample,
  input  logic                           i_complete,
  output logic [31:0]                    o_word
);

  // Select the word format from the pending class and whether the group is full.
  always_comb begin
    o_word = 32'd0;
    case (i_state)
      BASE_ACC: begin
        if (i_complete) begin
          o_word = {HDR_BASE_FULL, i_sample[NB_BASE-1:0], i_base_acc};
        end else begin
          o_word = {HDR_BASE_PART, {1'b0, i_cnt}, i_base_acc};
        end
      end
      SIG_ACC: begin
        if (i_complete) begin
          o_word = {HDR_SIG_PAIR, i_sample, i_sig_acc};
        end else begin
          o_word = {HDR_SIG_SINGLE, 13'd0, i_sig_acc};
        end
      end
      default: o_word = 32'd0;
    endcase
  end

endmodule

// File: rtl/ldtu_encoder.sv
// LiTe-DTU encoder: groups baseline samples five per word and signal samples
// two per word, flushing partial groups on class change or explicit flush.
module ldtu_encoder
  import ldtu_enc_pkg::*;
(
  input  logic        CLK,
  input  logic        rst,
  input  logic [12:0] DATA_to_enc,
  input  logic        baseline_flag,
  input  logic        in_valid,
  input  logic        flush,
  output logic [31:0] DATA_32,
  output logic        DATA_32_valid,
  output logic [15:0] word_cnt
);

  state_t                        r_state, w_state_nxt;
  logic [2:0]                    r_cnt, w_cnt_nxt;
  logic [(N_BASE-1)*NB_BASE-1:0] r_base_acc, w_base_acc_nxt;
  logic [NB_SIG-1:0]             r_sig_acc, w_sig_acc_nxt;
  logic                          w_emit, w_complete, w_start;
  logic [31:0]                   w_word;

  ldtu_enc_wordfmt u_wordfmt (
    .i_state    (r_state),
    .i_cnt      (r_cnt),
    .i_base_acc (r_base_acc),
    .i_sig_acc  (r_sig_acc),
    .i_sample   (DATA_to_enc),
    .i_complete (w_complete),
    .o_word     (w_word)
  );

  // Next-state logic: decide whether a word leaves and whether the new sample opens a group.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_base_acc_nxt = r_base_acc;
    w_sig_acc_nxt  = r_sig_acc;
    w_emit         = 1'b0;
    w_complete     = 1'b0;
    w_start        = 1'b0;
    case (r_state)
      EMPTY: begin
        w_start = in_valid;
      end
      BASE_ACC: begin
        if (flush) begin
          w_emit      = 1'b1;
          w_start     = in_valid;
          w_state_nxt = EMPTY;
        end else if (in_valid && baseline_flag) begin
          if (r_cnt == 3'd4) begin
            w_emit      = 1'b1;
            w_complete  = 1'b1;
            w_state_nxt = EMPTY;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
            case (r_cnt)
              3'd1:    w_base_acc_nxt[11:6]  = DATA_to_enc[5:0];
              3'd2:    w_base_acc_nxt[17:12] = DATA_to_enc[5:0];
              3'd3:    w_base_acc_nxt[23:18] = DATA_to_enc[5:0];
              default: w_base_acc_nxt        = r_base_acc;
            endcase
          end
        end else if (in_valid) begin
          w_emit  = 1'b1;
          w_start = 1'b1;
        end else begin
          w_emit = 1'b0;
        end
      end
      SIG_ACC: begin
        if (flush) begin
          w_emit      = 1'b1;
          w_start     = in_valid;
          w_state_nxt = EMPTY;
        end else if (in_valid && !baseline_flag) begin
          w_emit      = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = EMPTY;
        end else if (in_valid) begin
          w_emit  = 1'b1;
          w_start = 1'b1;
        end else begin
          w_emit = 1'b0;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase

    // A fresh group wipes the baseline accumulator so unused fields read as zero.
    if (w_start && baseline_flag) begin
      w_state_nxt    = BASE_ACC;
      w_cnt_nxt      = 3'd1;
      w_base_acc_nxt = {18'd0, DATA_to_enc[5:0]};
    end else if (w_start) begin
      w_state_nxt   = SIG_ACC;
      w_cnt_nxt     = 3'd0;
      w_sig_acc_nxt = DATA_to_enc;
    end else begin
      w_start = 1'b0;
    end
  end

  // State, accumulators and registered word outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state       <= EMPTY;
      r_cnt         <= 3'd0;
      r_base_acc    <= '0;
      r_sig_acc     <= '0;
      DATA_32       <= 32'd0;
      DATA_32_valid <= 1'b0;
      word_cnt      <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_base_acc    <= w_base_acc_nxt;
      r_sig_acc     <= w_sig_acc_nxt;
      DATA_32_valid <= w_emit;
      if (w_emit) begin
        DATA_32  <= w_word;
        word_cnt <= word_cnt + 16'd1;
      end else begin
        DATA_32  <= DATA_32;
        word_cnt <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_encoder.sv
// Scoreboard bench for ldtu_encoder: a sample-list reference model predicts
// words; a negedge monitor pops and compares whenever DATA_32_valid is high.
module tb_ldtu_encoder;

  logic        CLK;
  logic        rst;
  logic [12:0] DATA_to_enc;
  logic        baseline_flag;
  logic        in_valid;
  logic        flush;
  logic [31:0] DATA_32;
  logic        DATA_32_valid;
  logic [15:0] word_cnt;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [12:0] pend[$];
  bit          pend_base;
  logic [15:0] exp_cnt;

  ldtu_encoder dut (
    .CLK           (CLK),
    .rst           (rst),
    .DATA_to_enc   (DATA_to_enc),
    .baseline_flag (baseline_flag),
    .in_valid      (in_valid),
    .flush         (flush),
    .DATA_32       (DATA_32),
    .DATA_32_valid (DATA_32_valid),
    .word_cnt      (word_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word for the current pending list, built straight from the format table.
  function automatic logic [31:0] mk_word();
    logic [31:0] w;
    w = 32'd0;
    if (pend_base) begin
      for (int k = 0; k < pend.size(); k++)
        w = w + ({26'd0, pend[k][5:0]} << (6 * k));
      if (pend.size() == 5) w = w + 32'h4000_0000;
      else w = w + 32'hE000_0000 + (32'(pend.size()) << 24);
    end else if (pend.size() == 2) begin
      w = 32'h2800_0000 + ({19'd0, pend[1]} << 13) + {19'd0, pend[0]};
    end else begin
      w = 32'h2C00_0000 + {19'd0, pend[0]};
    end
    return w;
  endfunction

  task automatic emit_pending();
    exp_q.push_back(mk_word());
    pend.delete();
  endtask

  task automatic step(input logic v, input logic b, input logic [12:0] d, input logic f);
    @(posedge CLK);
    #1;
    in_valid      = v;
    baseline_flag = b;
    DATA_to_enc   = d;
    flush         = f;
    if (f && pend.size() > 0) emit_pending();
    if (v) begin
      if (pend.size() > 0 && pend_base != b) emit_pending();
      pend_base = b;
      pend.push_back(d);
      if ((b && pend.size() == 5) || (!b && pend.size() == 2)) emit_pending();
    end
  endtask

  task automatic base(input logic [5:0] d);
    step(1'b1, 1'b1, {7'd0, d}, 1'b0);
  endtask

  task automatic sig(input logic [12:0] d);
    step(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 13'd0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    checks++;
    if (DATA_32 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got=%h expected=00000000", DATA_32);
    end
    checks++;
    if (DATA_32_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b expected=0", DATA_32_valid);
    end
    checks++;
    if (word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_word_cnt got=%0d expected=0", word_cnt);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    pend.delete();
    @(posedge CLK);
    #1;
    rst = 1'b0;
    check_reset_outputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_words_missing expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every presented word must match the head of the scoreboard queue.
  always @(negedge CLK) begin : monitor
    logic [31:0] exp_w;
    if (DATA_32_valid === 1'b1) begin
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got=%h expected=no_word", DATA_32);
      end else begin
        exp_w = exp_q.pop_front();
        if (DATA_32 !== exp_w) begin
          errors++;
          $display("FAIL word got=%h expected=%h", DATA_32, exp_w);
        end
      end
      checks++;
      if (word_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL word_cnt got=%0d expected=%0d", word_cnt, exp_cnt);
      end
    end
    if (rst === 1'b1) exp_cnt = 16'd0;
  end

  initial begin
    bit          cls;
    logic [12:0] d;
    checks        = 0;
    errors        = 0;
    exp_cnt       = 16'd0;
    pend_base     = 1'b0;
    rst           = 1'b1;
    in_valid      = 1'b0;
    baseline_flag = 1'b0;
    flush         = 1'b0;
    DATA_to_enc   = 13'd0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    check_reset_outputs();

    for (int i = 1; i <= 5; i++) base(6'(i));
    idle(2);

    base(6'h0A); base(6'h0B); sig(13'h1ABC); sig(13'h0123);
    sig(13'h0FFF); base(6'h3F); step(1'b0, 1'b0, 13'd0, 1'b1);
    idle(1);

    for (int i = 0; i < 4; i++) base(6'(i + 7));
    step(1'b1, 1'b1, 13'h0015, 1'b1);
    for (int i = 0; i < 4; i++) base(6'(i + 33));
    idle(1);

    base(6'h11); base(6'h12); base(6'h13);
    do_reset();
    for (int i = 0; i < 5; i++) base(6'(i + 40));
    idle(1);

    sig(13'h1555); idle(3); sig(13'h0AAA);
    step(1'b0, 1'b0, 13'd0, 1'b1);
    idle(2);

    cls = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cls = ~cls;
      d = cls ? {7'd0, 6'($urandom)} : 13'($urandom);
      step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, cls, d,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b0, 13'd0, 1'b1);
    drain();

    do_reset();
    for (int i = 0; i < 65536; i++) begin
      if (i % 2 == 0) base(6'($urandom));
      else sig(13'($urandom));
    end
    step(1'b0, 1'b0, 13'd0, 1'b1);
    drain();
    checks++;
    if (word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL word_cnt_wrap got=%0d expected=0", word_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
